// File: rtl/fpu_stream_ctrl_if.sv
// Operand/result stream bundle between the FPU stream controller and its neighbours.
// slave is the controller's view; master is the view of the producer/consumer/FPU side.
interface fpu_stream_ctrl_if;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_a;
   logic [15:0] in_b;
   logic [15:0] fpu_a;
   logic [15:0] fpu_b;
   logic [15:0] fpu_r;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_r;
   logic        out_zero;

   modport slave (
      input  in_valid, in_a, in_b, fpu_r, out_ready,
      output in_ready, fpu_a, fpu_b, out_valid, out_r, out_zero
   );

   modport master (
      output in_valid, in_a, in_b, fpu_r, out_ready,
      input  in_ready, fpu_a, fpu_b, out_valid, out_r, out_zero
   );
endinterface

// File: rtl/fpu_stream_ctrl.sv
// FIFO-buffered front-end for a combinational binary16 adder; result out_valid at push edge +2+SETTLE.
// in_ready is !full only, out_valid holds until handshake; FPU_STREAM_STATS_EN adds op_count.
module fpu_stream_ctrl #(
   parameter int FIFO_DEPTH = 4,
   parameter int SETTLE     = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   fpu_stream_ctrl_if.slave   strm,
`ifdef FPU_STREAM_STATS_EN
   output logic [15:0]        op_count,
`endif
   output logic               busy
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   typedef struct packed {
      logic [15:0] a;
      logic [15:0] b;
   } pair_t;

   typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_e;

   pair_t           mem_q [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]   count_q, count_d;
   state_e          state_q, state_d;
   logic [3:0]      cnt_q, cnt_d;
   logic [15:0]     fpu_a_q, fpu_b_q;
   logic [15:0]     out_r_q;
   logic            out_zero_q;
   logic            out_valid_q, out_valid_d;
   logic            push, pop, capture;
   logic            empty, full;
   pair_t           head;

   assign empty = (count_q == '0);
   assign full  = (count_q == CW'(FIFO_DEPTH));
   assign push  = strm.in_valid && !full;
   assign head  = mem_q[rd_ptr_q];

   assign strm.in_ready  = !full;
   assign strm.fpu_a     = fpu_a_q;
   assign strm.fpu_b     = fpu_b_q;
   assign strm.out_valid = out_valid_q;
   assign strm.out_r     = out_r_q;
   assign strm.out_zero  = out_zero_q;
   assign busy           = (state_q != IDLE) || !empty;

   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Pops only come from the FSM, so a pop never frees space for a same-edge push while full.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      out_valid_d = out_valid_q;
      pop         = 1'b0;
      capture     = 1'b0;
      case (state_q)
         IDLE: begin
            if (!empty) begin
               pop     = 1'b1;
               cnt_d   = 4'(SETTLE);
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            if (cnt_q == 4'd0) begin
               capture     = 1'b1;
               out_valid_d = 1'b1;
               state_d     = HOLD;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         HOLD: begin
            if (out_valid_q && strm.out_ready) begin
               out_valid_d = 1'b0;
               if (!empty) begin
                  pop     = 1'b1;
                  cnt_d   = 4'(SETTLE);
                  state_d = ISSUE;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= pair_t'({strm.in_a, strm.in_b});
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         state_q     <= IDLE;
         cnt_q       <= 4'd0;
         fpu_a_q     <= 16'h0000;
         fpu_b_q     <= 16'h0000;
         out_r_q     <= 16'h0000;
         out_zero_q  <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         count_q     <= count_d;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         if (push) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
            fpu_a_q  <= head.a;
            fpu_b_q  <= head.b;
         end
         if (capture) begin
            out_r_q    <= strm.fpu_r;
            out_zero_q <= (strm.fpu_r[14:0] == 15'd0);
         end
      end
   end

`ifdef FPU_STREAM_STATS_EN
   logic [15:0] op_count_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_count_q <= 16'h0000;
      end else if (out_valid_q && strm.out_ready) begin
         op_count_q <= op_count_q + 16'd1;
      end
   end

   assign op_count = op_count_q;
`endif

endmodule

// File: tb/tb_fpu_stream_ctrl.sv
// Directed bench: two controllers (SETTLE=1 and SETTLE=0) around a behavioural binary16 adder.
module tb_fpu_stream_ctrl;

   logic        clk;
   logic        rst_n;
   logic        busy0, busy1;
`ifdef FPU_STREAM_STATS_EN
   logic [15:0] op0, op1;
`endif

   fpu_stream_ctrl_if i0 ();
   fpu_stream_ctrl_if i1 ();

   fpu_stream_ctrl #(.FIFO_DEPTH(4), .SETTLE(1)) u_dut0 (
      .clk      (clk),
      .rst_n    (rst_n),
      .strm     (i0),
`ifdef FPU_STREAM_STATS_EN
      .op_count (op0),
`endif
      .busy     (busy0)
   );

   fpu_stream_ctrl #(.FIFO_DEPTH(4), .SETTLE(0)) u_dut1 (
      .clk      (clk),
      .rst_n    (rst_n),
      .strm     (i1),
`ifdef FPU_STREAM_STATS_EN
      .op_count (op1),
`endif
      .busy     (busy1)
   );

   // Normal-number adder with truncation; enough for the exact-result vectors below.
   function automatic logic [15:0] fadd(input logic [15:0] x, input logic [15:0] y);
      logic [15:0] p, q;
      logic [11:0] mp, mq, m;
      int          e, d;
      if (x[14:0] < y[14:0]) begin p = y; q = x; end
      else begin p = x; q = y; end
      mp = {1'b0, (p[14:10] != 5'd0), p[9:0]};
      mq = {1'b0, (q[14:10] != 5'd0), q[9:0]};
      d  = int'(p[14:10]) - int'(q[14:10]);
      mq = mq >> d;
      e  = int'(p[14:10]);
      if (p[15] == q[15]) m = mp + mq;
      else m = mp - mq;
      if (m == 12'd0) return 16'h0000;
      if (m[11]) begin m = m >> 1; e = e + 1; end
      while (!m[10] && e > 1) begin m = m << 1; e = e - 1; end
      return {p[15], 5'(e), m[9:0]};
   endfunction

   assign i0.fpu_r = fadd(i0.fpu_a, i0.fpu_b);
   assign i1.fpu_r = fadd(i1.fpu_a, i1.fpu_b);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int acc0 = 0, acc1 = 0, hs0 = 0, hs1 = 0;
   logic [31:0] q0[$];
   logic [31:0] q1[$];

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic drive();
      if (q0.size() != 0) begin i0.in_valid = 1'b1; {i0.in_a, i0.in_b} = q0[0]; end
      else i0.in_valid = 1'b0;
      if (q1.size() != 0) begin i1.in_valid = 1'b1; {i1.in_a, i1.in_b} = q1[0]; end
      else i1.in_valid = 1'b0;
   endtask

   task automatic tick();
      bit f0, f1, h0, h1;
      f0 = i0.in_valid && i0.in_ready;
      f1 = i1.in_valid && i1.in_ready;
      h0 = i0.out_valid && i0.out_ready;
      h1 = i1.out_valid && i1.out_ready;
      @(posedge clk);
      #1;
      if (f0) begin void'(q0.pop_front()); acc0++; end
      if (f1) begin void'(q1.pop_front()); acc1++; end
      if (h0) hs0++;
      if (h1) hs1++;
      drive();
   endtask

   task automatic wait_ov0(input string tag);
      int n = 0;
      while (!i0.out_valid && n < 20) begin tick(); n++; end
      chk(tag, 16'(i0.out_valid), 16'd1);
   endtask

   task automatic run_one(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] er, input logic ez);
      q0.push_back({a, b});
      drive();
      wait_ov0({tag, "_wait"});
      chk({tag, "_r"}, i0.out_r, er);
      chk({tag, "_zero"}, 16'(i0.out_zero), 16'(ez));
      i0.out_ready = 1'b1;
      tick();
      i0.out_ready = 1'b0;
      chk({tag, "_done"}, 16'(i0.out_valid), 16'd0);
   endtask

   logic [31:0] vin [8] = '{32'h3C00_3800, 32'h4000_4000, 32'h4200_3C00, 32'h4400_BC00,
                            32'h3800_3800, 32'h3C00_4000, 32'h4000_C000, 32'h3C00_3C00};
   logic [15:0] vout[8] = '{16'h3E00, 16'h4400, 16'h4400, 16'h4200,
                            16'h3C00, 16'h4200, 16'h0000, 16'h4000};

   initial begin
      int base, last, got, cyc, seen, n;
      rst_n = 1'b0;
      i0.in_a = 16'h0; i0.in_b = 16'h0; i1.in_a = 16'h0; i1.in_b = 16'h0;
      i0.out_ready = 1'b0;
      i1.out_ready = 1'b1;
      drive();
      #12;
      chk("rst_fpu_a", i0.fpu_a, 16'h0000);
      chk("rst_out_valid", 16'(i0.out_valid), 16'd0);
      chk("rst_in_ready", 16'(i0.in_ready), 16'd1);
      chk("rst_busy", 16'(busy0), 16'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Single op latency: push edge 0, operands after edge 1, result after edge 3.
      q0.push_back({16'h3C00, 16'h3C00});
      drive();
      tick();
      chk("lat_e0_fpu_a", i0.fpu_a, 16'h0000);
      chk("lat_e0_busy", 16'(busy0), 16'd1);
      tick();
      chk("lat_e1_fpu_a", i0.fpu_a, 16'h3C00);
      chk("lat_e1_fpu_b", i0.fpu_b, 16'h3C00);
      chk("lat_e1_ov", 16'(i0.out_valid), 16'd0);
      tick();
      chk("lat_e2_ov", 16'(i0.out_valid), 16'd0);
      tick();
      chk("lat_e3_ov", 16'(i0.out_valid), 16'd1);
      chk("lat_e3_r", i0.out_r, 16'h4000);
      chk("lat_e3_zero", 16'(i0.out_zero), 16'd0);
      tick(); tick();
      chk("lat_hold_ov", 16'(i0.out_valid), 16'd1);
      chk("lat_hold_r", i0.out_r, 16'h4000);
      i0.out_ready = 1'b1;
      tick();
      i0.out_ready = 1'b0;
      chk("lat_hs_ov", 16'(i0.out_valid), 16'd0);
      chk("lat_hs_busy", 16'(busy0), 16'd0);

      run_one("zero", 16'h4000, 16'hC000, 16'h0000, 1'b1);
      run_one("add12", 16'h3C00, 16'h4000, 16'h4200, 1'b0);

      // Backpressure: 4 queued + 1 in flight accepted, sixth held.
      base = acc0;
      for (int k = 0; k < 6; k++) q0.push_back(vin[k]);
      drive();
      repeat (10) tick();
      chk("bp_accepted", 16'(acc0 - base), 16'd5);
      chk("bp_in_ready", 16'(i0.in_ready), 16'd0);
      chk("bp_held", 16'(i0.in_valid), 16'd1);
      chk("bp_stall_ov", 16'(i0.out_valid), 16'd1);
      chk("bp_stall_r0", i0.out_r, 16'h3E00);
      repeat (3) tick();
      chk("bp_stall_r1", i0.out_r, 16'h3E00);
      i0.out_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         wait_ov0("bp_wait");
         chk("bp_r", i0.out_r, vout[k]);
         tick();
      end
      i0.out_ready = 1'b0;
      chk("bp_all_in", 16'(acc0 - base), 16'd6);
      chk("bp_busy", 16'(busy0), 16'd0);
`ifdef FPU_STREAM_STATS_EN
      chk("stats0", op0, 16'(hs0));
`endif

      // Streaming with SETTLE=0: one result every 2 cycles.
      for (int k = 0; k < 8; k++) q1.push_back(vin[k]);
      drive();
      last = 0; got = 0; cyc = 0;
      for (int t = 0; t < 60 && got < 8; t++) begin
         if (i1.out_valid) begin
            chk("strm_r", i1.out_r, vout[got]);
            if (got > 0) chk("strm_gap", 16'(cyc - last), 16'd2);
            last = cyc;
            got++;
         end
         tick();
         cyc++;
      end
      chk("strm_cnt", 16'(got), 16'd8);
      chk("strm_busy", 16'(busy1), 16'd0);

`ifdef FPU_STREAM_STATS_EN
      chk("stats_8", op1, 16'd8);
      for (int k = 0; k < 65536 - 8; k++) q1.push_back(vin[k % 8]);
      drive();
      n = 0;
      while (hs1 < 65536 && n < 140000) begin tick(); n++; end
      chk("stats_wrap", op1, 16'h0000);
      for (int k = 0; k < 3; k++) q1.push_back(vin[k]);
      drive();
      n = 0;
      while (hs1 < 65539 && n < 40) begin tick(); n++; end
      chk("stats_3", op1, 16'd3);
`endif

      // Reset with a zero result pending and more pairs queued.
      q0.push_back({16'h4000, 16'hC000});
      q0.push_back(vin[0]);
      q0.push_back(vin[1]);
      drive();
      wait_ov0("mrst_wait");
      chk("mrst_pre_zero", 16'(i0.out_zero), 16'd1);
      #3;
      rst_n = 1'b0;
      q0.delete();
      q1.delete();
      drive();
      #1;
      chk("mrst_ov", 16'(i0.out_valid), 16'd0);
      chk("mrst_zero", 16'(i0.out_zero), 16'd0);
      chk("mrst_r", i0.out_r, 16'h0000);
      chk("mrst_fpu_b", i0.fpu_b, 16'h0000);
      chk("mrst_busy", 16'(busy0), 16'd0);
      chk("mrst_in_ready", 16'(i0.in_ready), 16'd1);
`ifdef FPU_STREAM_STATS_EN
      chk("mrst_stats", op0, 16'h0000);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      i0.out_ready = 1'b1;
      seen = 0;
      repeat (10) begin
         tick();
         if (i0.out_valid) seen++;
      end
      chk("mrst_no_out", 16'(seen), 16'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
